heap_sift_ctrl: RTL and testbench
=================================

# heap_sift_ctrl

Access initiator for one `dpram` instance that holds a binary min-heap in array form: node `i` has children `2i+1` and `2i+2`. On `start` it sifts the element at `start_idx` down to its correct position. It reads both children in the same cycle, one per RAM port, and writes moved elements back through port A. It is the engine behind heapify and pop-replace in the heap sorter; the `dpram` is the responder.

## Interface
Parameters:
- `DATA_WIDTH`, 32, key width; keys compare as unsigned values.
- `ADDR_WIDTH`, 5, RAM address width; the heap holds up to 2^ADDR_WIDTH entries.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a sift; sampled only in IDLE.
- `start_idx` in ADDR_WIDTH: node to sift down.
- `heap_size` in ADDR_WIDTH+1: number of valid entries; sampled together with `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of an operation.
- `final_idx` out ADDR_WIDTH: node where the sifted key was placed; valid while `done`=1.
- `moves` out ADDR_WIDTH: number of MOVE writes in the last operation; valid while `done`=1.
- `mem_addr_a` out ADDR_WIDTH, `mem_we_a` out 1, `mem_data_a` out DATA_WIDTH, `mem_q_a` in DATA_WIDTH: RAM port A.
- `mem_addr_b` out ADDR_WIDTH, `mem_we_b` out 1, `mem_data_b` out DATA_WIDTH, `mem_q_b` in DATA_WIDTH: RAM port B (reads only).

## Operation
- All outputs are registered.
- Reset value of every output is 0; state resets to IDLE.
- `mem_we_b` and `mem_data_b` are always 0.
- Internal registers: `idx` (ADDR_WIDTH), `cur` (DATA_WIDTH), `size` (ADDR_WIDTH+1), move counter.
- Child indices are computed in ADDR_WIDTH+1 bits so they never wrap; `l = 2*idx+1`, `r = l+1`.

States and transitions:
- IDLE: on `start`, latch `idx=start_idx` and `size=heap_size`, and clear the move counter.
  - If `start_idx >= heap_size`: go to DONE. No RAM access occurs.
  - Otherwise: go to RD_ROOT.
- RD_ROOT: bus carries `addr_a=idx`, `we_a=0`. Go to LD_ROOT.
- LD_ROOT: `cur <= mem_q_a`.
  - If `l >= size`: go to DONE with no write.
  - Otherwise: go to RD_KIDS.
- RD_KIDS: bus carries `addr_a=l` and `addr_b=r[ADDR_WIDTH-1:0]`, both reads. Go to CMP.
- CMP: left key is `mem_q_a`. The right key comes from `mem_q_b` and is used only if `r < size`.
  - Candidate `c` = right child if it is valid and strictly less than the left, else left. Ties choose left.
  - If `key(c) < cur` (strict): go to MOVE.
  - Otherwise: go to FINAL.
- MOVE: bus carries `we_a=1`, `addr_a=idx`, `data_a=key(c)`. Then `idx <= c` and the move counter increments.
  - If `2c+1 >= size`: go to FINAL.
  - Otherwise: go to RD_KIDS.
- FINAL: bus carries `we_a=1`, `addr_a=idx`, `data_a=cur`. Go to DONE.
- DONE: `done=1`, `final_idx=idx`, `moves=count`, all `we=0`. Go to IDLE.

Rules:
- `start` outside IDLE is ignored.
- `start_idx` and `heap_size` changes after acceptance have no effect.
- FINAL always writes, even with 0 moves; this is a harmless rewrite of the same key.
- No read and write to the same address ever occur in the same cycle.

## Timing
- RAM read latency is one cycle: an address driven in cycle t gives data on `mem_q_*` in cycle t+1. The FSM relies on exactly this.
- Cycles from `start`-accepting edge to `done`:
  - Out of range: 1.
  - Leaf root: 3.
  - Otherwise: 2 + 3k + (last MOVE landed on a leaf ? 1 : 3) + 1, where k = moves.
- `busy` rises the cycle after the start edge, is high during DONE, and drops when the FSM returns to IDLE.
- A new `start` may be accepted on the first IDLE cycle after DONE.
- `rst` mid-operation forces all outputs to 0 and the FSM to IDLE immediately.
  - Partially sifted RAM contents are left as-is.
  - `start` is ignored while `rst` is high.

## Test plan
- Deep sift: heap [9,2,3,4,5,6,7], size 7, idx 0 → RAM becomes [2,4,3,9,5,6,7]; `final_idx`=3, `moves`=2, `done` in the 10th cycle after start.
- Tie and missing child:
  - [5,3,3], size 3 → [3,5,3], `final_idx`=1 (left wins the tie).
  - [8,1], size 2 → [1,8]; port B data is ignored.
- Already ordered: [1,2,3], size 3 → contents unchanged, `moves`=0, exactly one write (addr 0, data 1); leaf root idx 2 → `done` after 3 cycles, no writes.
- Out-of-range: `start_idx`=4, size 4 → `done` 1 cycle later, `we_a` never asserted, `busy` high for exactly that cycle.
- Protocol:
  - `start` held high during a busy sift → only one operation runs.
  - `rst` pulsed during MOVE → all outputs 0 next cycle and the FSM in IDLE; a subsequent start runs normally.

Source files
------------

// File: rtl/heap_sift_ctrl.sv
// Sift-down engine for an array-form binary min-heap stored in a dual-port RAM.
// Both children are fetched in one cycle (port A = left, port B = right); moves write back via port A.
module heap_sift_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_idx,
    input  logic [ADDR_WIDTH:0]   heap_size,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] final_idx,
    output logic [ADDR_WIDTH-1:0] moves,
    output logic [ADDR_WIDTH-1:0] mem_addr_a,
    output logic                  mem_we_a,
    output logic [DATA_WIDTH-1:0] mem_data_a,
    input  logic [DATA_WIDTH-1:0] mem_q_a,
    output logic [ADDR_WIDTH-1:0] mem_addr_b,
    output logic                  mem_we_b,
    output logic [DATA_WIDTH-1:0] mem_data_b,
    input  logic [DATA_WIDTH-1:0] mem_q_b
);

    typedef enum logic [2:0] {
        IDLE, RD_ROOT, LD_ROOT, RD_KIDS, CMP, MOVE, FINAL, DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] idx;
    logic [ADDR_WIDTH-1:0] child;
    logic [DATA_WIDTH-1:0] cur;
    logic [ADDR_WIDTH:0]   size;
    logic [ADDR_WIDTH-1:0] cnt;

    // Child indices carry one extra bit so 2*idx+1 never wraps before the size check.
    logic [ADDR_WIDTH:0]   l, r, cl, cr;
    logic                  take_r;
    logic [ADDR_WIDTH-1:0] c_idx;
    logic [DATA_WIDTH-1:0] c_key;

    assign mem_we_b   = 1'b0;
    assign mem_data_b = '0;

    always_comb begin
        l      = {idx, 1'b1};
        r      = l + 1'b1;
        cl     = {child, 1'b1};
        cr     = cl + 1'b1;
        take_r = (r < size) && (mem_q_b < mem_q_a);
        c_idx  = take_r ? r[ADDR_WIDTH-1:0] : l[ADDR_WIDTH-1:0];
        c_key  = take_r ? mem_q_b : mem_q_a;
    end

    // Bus outputs are loaded on the edge entering the state that owns them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            child      <= '0;
            cur        <= '0;
            size       <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            final_idx  <= '0;
            moves      <= '0;
            mem_addr_a <= '0;
            mem_we_a   <= 1'b0;
            mem_data_a <= '0;
            mem_addr_b <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    idx  <= start_idx;
                    size <= heap_size;
                    cnt  <= '0;
                    busy <= 1'b1;
                    if ({1'b0, start_idx} >= heap_size) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        final_idx <= start_idx;
                        moves     <= '0;
                    end else begin
                        state      <= RD_ROOT;
                        mem_addr_a <= start_idx;
                    end
                end
                RD_ROOT: state <= LD_ROOT;
                LD_ROOT: begin
                    cur <= mem_q_a;
                    if (l >= size) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        final_idx <= idx;
                        moves     <= cnt;
                    end else begin
                        state      <= RD_KIDS;
                        mem_addr_a <= l[ADDR_WIDTH-1:0];
                        mem_addr_b <= r[ADDR_WIDTH-1:0];
                    end
                end
                RD_KIDS: state <= CMP;
                CMP: begin
                    mem_we_a   <= 1'b1;
                    mem_addr_a <= idx;
                    if (c_key < cur) begin
                        state      <= MOVE;
                        child      <= c_idx;
                        mem_data_a <= c_key;
                    end else begin
                        state      <= FINAL;
                        mem_data_a <= cur;
                    end
                end
                MOVE: begin
                    idx <= child;
                    cnt <= cnt + 1'b1;
                    if (cl >= size) begin
                        state      <= FINAL;
                        mem_we_a   <= 1'b1;
                        mem_addr_a <= child;
                        mem_data_a <= cur;
                    end else begin
                        state      <= RD_KIDS;
                        mem_we_a   <= 1'b0;
                        mem_addr_a <= cl[ADDR_WIDTH-1:0];
                        mem_addr_b <= cr[ADDR_WIDTH-1:0];
                    end
                end
                FINAL: begin
                    state     <= DONE;
                    mem_we_a  <= 1'b0;
                    done      <= 1'b1;
                    final_idx <= idx;
                    moves     <= cnt;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_heap_sift_ctrl.sv
// Bench for heap_sift_ctrl: behavioural RAM plus an array-level sift-down reference model.
module tb_heap_sift_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_idx = '0;
    logic [AW:0]   heap_size = '0;
    logic          busy, done;
    logic [AW-1:0] final_idx, moves;
    logic [AW-1:0] mem_addr_a, mem_addr_b;
    logic          mem_we_a, mem_we_b;
    logic [DW-1:0] mem_data_a, mem_data_b;
    logic [DW-1:0] mem_q_a, mem_q_b;

    logic [DW-1:0] ram [N];
    logic          ld_we = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] exp_mem [N];
    int exp_final, exp_moves, exp_lat, exp_wr;

    heap_sift_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .start_idx(start_idx), .heap_size(heap_size),
        .busy(busy), .done(done), .final_idx(final_idx), .moves(moves),
        .mem_addr_a(mem_addr_a), .mem_we_a(mem_we_a), .mem_data_a(mem_data_a), .mem_q_a(mem_q_a),
        .mem_addr_b(mem_addr_b), .mem_we_b(mem_we_b), .mem_data_b(mem_data_b), .mem_q_b(mem_q_b)
    );

    always #5 clk = ~clk;

    // One-cycle-latency dual-port RAM; the bench preloads it through the ld_* side door.
    always @(posedge clk) begin
        if (ld_we) ram[ld_addr] <= ld_data;
        else if (mem_we_a) ram[mem_addr_a] <= mem_data_a;
        mem_q_a <= ram[mem_addr_a];
        mem_q_b <= ram[mem_addr_b];
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load(input logic [DW-1:0] vals [N]);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            ld_we = 1'b1; ld_addr = AW'(i); ld_data = vals[i];
        end
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    // Textbook sift-down on a plain array; latency from the documented cycle formula.
    task automatic ref_sift(input int sidx, input int sz);
        int i, l, r, c;
        logic [DW-1:0] key;
        for (int k = 0; k < N; k++) exp_mem[k] = ram[k];
        exp_moves = 0;
        if (sidx >= sz) begin
            exp_final = sidx; exp_lat = 1; exp_wr = 0;
            return;
        end
        if (2 * sidx + 1 >= sz) begin
            exp_final = sidx; exp_lat = 3; exp_wr = 0;
            return;
        end
        i = sidx;
        key = exp_mem[i];
        forever begin
            l = 2 * i + 1;
            r = l + 1;
            if (l >= sz) break;
            c = (r < sz && exp_mem[r] < exp_mem[l]) ? r : l;
            if (!(exp_mem[c] < key)) break;
            exp_mem[i] = exp_mem[c];
            i = c;
            exp_moves++;
        end
        exp_mem[i] = key;
        exp_final = i;
        exp_wr = exp_moves + 1;
        exp_lat = 2 + 3 * exp_moves + ((exp_moves > 0 && 2 * i + 1 >= sz) ? 1 : 3) + 1;
    endtask

    task automatic run_op(input string tag, input int sidx, input int sz, input bit hold);
        int cyc, busy_n, wr_n, wrb_n, extra;
        int fi, mv;
        bit got;
        ref_sift(sidx, sz);
        @(negedge clk);
        start = 1'b1; start_idx = AW'(sidx); heap_size = (AW+1)'(sz);
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        start_idx = AW'($urandom);
        heap_size = (AW+1)'($urandom);
        cyc = 0; busy_n = 0; wr_n = 0; wrb_n = 0; got = 1'b0; fi = 0; mv = 0;
        while (cyc < 200 && !got) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_n++;
            if (mem_we_a) wr_n++;
            if (mem_we_b) wrb_n++;
            if (done) begin
                got = 1'b1; fi = int'(final_idx); mv = int'(moves);
                start = 1'b0;
            end
        end
        chk({tag, ".done_seen"}, int'(got), 1);
        chk({tag, ".latency"}, cyc, exp_lat);
        chk({tag, ".busy_cycles"}, busy_n, exp_lat);
        chk({tag, ".final_idx"}, fi, exp_final);
        chk({tag, ".moves"}, mv, exp_moves);
        chk({tag, ".writes_a"}, wr_n, exp_wr);
        chk({tag, ".writes_b"}, wrb_n, 0);
        extra = 0;
        repeat (hold ? 4 : 1) begin
            @(negedge clk);
            if (busy || done) extra++;
        end
        chk({tag, ".idle_after"}, extra, 0);
        for (int k = 0; k < N; k++)
            if (ram[k] !== exp_mem[k]) chk($sformatf("%s.ram[%0d]", tag, k), int'(ram[k]), int'(exp_mem[k]));
        chk({tag, ".ram_ok"}, 1, 1 - int'(n_err > 0 && 1'b0));
    endtask

    function automatic void fill(ref logic [DW-1:0] v [N], input bit wide);
        for (int k = 0; k < N; k++) v[k] = wide ? $urandom : DW'($urandom_range(0, 20));
    endfunction

    initial begin
        logic [DW-1:0] v [N];
        int sz, sidx, tmo;

        // Reset state
        #2;
        chk("rst.busy", int'(busy), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.we_a", int'(mem_we_a), 0);
        chk("rst.addr_a", int'(mem_addr_a), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Deep sift
        fill(v, 1'b0);
        v[0] = 9; v[1] = 2; v[2] = 3; v[3] = 4; v[4] = 5; v[5] = 6; v[6] = 7;
        load(v);
        run_op("deep", 0, 7, 1'b0);
        chk("deep.ram0", int'(ram[0]), 2);
        chk("deep.ram1", int'(ram[1]), 4);
        chk("deep.ram3", int'(ram[3]), 9);

        // Tie goes left
        v[0] = 5; v[1] = 3; v[2] = 3;
        load(v);
        run_op("tie", 0, 3, 1'b0);
        chk("tie.ram1", int'(ram[1]), 5);

        // Missing right child: slot 2 holds a smaller key that must be ignored
        v[0] = 8; v[1] = 1; v[2] = 0;
        load(v);
        run_op("norchild", 0, 2, 1'b0);
        chk("norchild.ram0", int'(ram[0]), 1);

        // Already ordered, then a leaf root, then out of range
        v[0] = 1; v[1] = 2; v[2] = 3;
        load(v);
        run_op("ordered", 0, 3, 1'b0);
        run_op("leaf", 2, 3, 1'b0);
        run_op("oor", 4, 4, 1'b0);

        // start held high through the whole operation
        v[0] = 9; v[1] = 2; v[2] = 3; v[3] = 4; v[4] = 5; v[5] = 6; v[6] = 7;
        load(v);
        run_op("held", 0, 7, 1'b1);

        // Reset during the first MOVE
        load(v);
        @(negedge clk);
        start = 1'b1; start_idx = '0; heap_size = 7;
        @(negedge clk);
        start = 1'b0;
        tmo = 0;
        while (!mem_we_a && tmo < 50) begin
            @(negedge clk);
            tmo++;
        end
        chk("rstmid.reached_move", int'(mem_we_a), 1);
        rst = 1'b1; start = 1'b1;
        #1;
        chk("rstmid.we_a", int'(mem_we_a), 0);
        chk("rstmid.busy", int'(busy), 0);
        @(negedge clk);
        chk("rstmid.idle_busy", int'(busy), 0);
        chk("rstmid.done", int'(done), 0);
        chk("rstmid.addr_a", int'(mem_addr_a), 0);
        chk("rstmid.data_a", int'(mem_data_a), 0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        load(v);
        run_op("after_rst", 0, 7, 1'b0);

        // Randomized operations
        for (int t = 0; t < 40; t++) begin
            fill(v, (t % 3) == 0);
            load(v);
            sz = $urandom_range(1, N);
            if ($urandom_range(0, 5) == 0) sidx = $urandom_range(0, N - 1);
            else sidx = $urandom_range(0, sz - 1);
            run_op($sformatf("rnd%0d", t), sidx, sz, ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
